// File: rtl/sha256_msg_padder.sv
`default_nettype none
// ============================================================================
// Module   : sha256_msg_padder
// Brief    : Streaming SHA-256 padder; big-endian 32-bit words in, 16-word padded blocks out.
// Revision : 1.0 - initial release
// ============================================================================
module sha256_msg_padder #(
    parameter int CNT_W = 32
) (
    input  logic        iClk,
    input  logic        iReset_n,
    input  logic        iClear,
    input  logic        iIn_valid,
    input  logic [31:0] iIn_data,
    input  logic        iIn_last,
    input  logic [2:0]  iIn_nbytes,
    output logic        oIn_ready,
    output logic        oOut_valid,
    output logic [31:0] oOut_data,
    output logic        oOut_first,
    output logic        oOut_last,
    output logic        oOut_final,
    input  logic        iOut_ready,
    output logic        oBusy,
    output logic        oErr
);

    typedef enum logic [2:0] {
        S_DATA   = 3'd0,
        S_MARK   = 3'd1,
        S_ZERO   = 3'd2,
        S_LEN_HI = 3'd3,
        S_LEN_LO = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic             w_xfer;
    logic             w_bad_nb;
    logic [2:0]       w_nb;
    logic             w_partial;
    logic [3:0]       w_idx_inc;
    logic [CNT_W:0]   w_sum;
    logic [63:0]      w_len;
    logic [31:0]      w_pad_word;
    state_t           w_pad_next;

    assign w_bad_nb   = (iIn_nbytes > 3'd4);
    assign w_nb       = w_bad_nb ? 3'd4 : iIn_nbytes;
    assign w_partial  = iIn_last && (w_nb != 3'd4);
    assign w_idx_inc  = idx_q + 4'd1;
    assign w_sum      = {1'b0, cnt_q} + (w_partial ? (CNT_W+1)'(w_nb) : (CNT_W+1)'(4));
    assign w_len      = 64'(cnt_q) << 3;
    // Padding skips straight to the length words once they would land on idx 14/15.
    assign w_pad_next = (w_idx_inc == 4'd14) ? S_LEN_HI : S_ZERO;

    always_comb begin
        case (w_nb[1:0])
            2'd0:    w_pad_word = 32'h8000_0000;
            2'd1:    w_pad_word = {iIn_data[31:24], 24'h80_0000};
            2'd2:    w_pad_word = {iIn_data[31:16], 16'h8000};
            default: w_pad_word = {iIn_data[31:8], 8'h80};
        endcase
    end

    always_comb begin
        oIn_ready  = 1'b0;
        oOut_valid = 1'b0;
        oOut_data  = 32'h0;
        oOut_final = 1'b0;
        case (state_q)
            S_DATA: begin
                oIn_ready  = iOut_ready;
                oOut_valid = iIn_valid;
                if (iIn_valid) begin
                    oOut_data = w_partial ? w_pad_word : iIn_data;
                end
            end
            S_MARK: begin
                oOut_valid = 1'b1;
                oOut_data  = 32'h8000_0000;
            end
            S_ZERO: begin
                oOut_valid = 1'b1;
            end
            S_LEN_HI: begin
                oOut_valid = 1'b1;
                oOut_data  = w_len[63:32];
            end
            S_LEN_LO: begin
                oOut_valid = 1'b1;
                oOut_data  = w_len[31:0];
                oOut_final = 1'b1;
            end
            default: ;
        endcase
    end

    assign oOut_first = oOut_valid && (idx_q == 4'd0);
    assign oOut_last  = oOut_valid && (idx_q == 4'd15);
    assign w_xfer     = oOut_valid && iOut_ready;
    assign oBusy      = (state_q != S_DATA) || (idx_q != 4'd0) || (cnt_q != '0);
    assign oErr       = err_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (w_xfer) begin
            idx_d = w_idx_inc;
            case (state_q)
                S_DATA: begin
                    cnt_d = w_sum[CNT_W-1:0];
                    if (w_sum[CNT_W] || (iIn_last && w_bad_nb)) begin
                        err_d = 1'b1;
                    end
                    if (iIn_last) begin
                        state_d = w_partial ? w_pad_next : S_MARK;
                    end
                end
                S_MARK, S_ZERO: state_d = w_pad_next;
                S_LEN_HI:       state_d = S_LEN_LO;
                S_LEN_LO: begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end
                default:        state_d = S_DATA;
            endcase
        end
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q <= S_DATA;
            idx_q   <= 4'd0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else if (iClear) begin
            state_q <= S_DATA;
            idx_q   <= 4'd0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sha256_msg_padder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha256_msg_padder
// Brief    : Directed bench for sha256_msg_padder against a byte-level padding model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha256_msg_padder;

    localparam int CNT_W = 8;

    logic        iClk = 1'b0;
    logic        iReset_n, iClear, iIn_valid, iIn_last, iOut_ready;
    logic [31:0] iIn_data;
    logic [2:0]  iIn_nbytes;
    logic        oIn_ready, oOut_valid, oOut_first, oOut_last, oOut_final, oBusy, oErr;
    logic [31:0] oOut_data;

    sha256_msg_padder #(.CNT_W(CNT_W)) dut (
        .iClk       (iClk),
        .iReset_n   (iReset_n),
        .iClear     (iClear),
        .iIn_valid  (iIn_valid),
        .iIn_data   (iIn_data),
        .iIn_last   (iIn_last),
        .iIn_nbytes (iIn_nbytes),
        .oIn_ready  (oIn_ready),
        .oOut_valid (oOut_valid),
        .oOut_data  (oOut_data),
        .oOut_first (oOut_first),
        .oOut_last  (oOut_last),
        .oOut_final (oOut_final),
        .iOut_ready (iOut_ready),
        .oBusy      (oBusy),
        .oErr       (oErr)
    );

    always #5 iClk = ~iClk;

    typedef struct packed {
        logic [31:0] data;
        logic        first;
        logic        last;
        logic        fin;
    } exp_t;

    exp_t       exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         acc_cnt = 0;
    bit         stall_en = 0;
    logic [7:0] msg [0:299];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Padded stream from first principles: message, 0x80, zeros to 56 mod 64, 64-bit bit length.
    task automatic push_expected(input int n);
        logic [7:0]  s[$];
        logic [63:0] len;
        int          nw;
        exp_t        e;
        for (int i = 0; i < n; i++) s.push_back(msg[i]);
        s.push_back(8'h80);
        while (s.size() % 64 != 56) s.push_back(8'h00);
        len = 64'(n % (1 << CNT_W)) * 64'd8;
        for (int k = 7; k >= 0; k--) s.push_back(len[8*k +: 8]);
        nw = s.size() / 4;
        for (int w = 0; w < nw; w++) begin
            e.data  = {s[4*w], s[4*w+1], s[4*w+2], s[4*w+3]};
            e.first = (w % 16 == 0);
            e.last  = (w % 16 == 15);
            e.fin   = (w == nw - 1);
            exp_q.push_back(e);
        end
    endtask

    function automatic logic [31:0] mkw(input int w);
        return {msg[4*w], msg[4*w+1], msg[4*w+2], msg[4*w+3]};
    endfunction

    task automatic fill_pattern();
        for (int i = 0; i < 300; i++) msg[i] = 8'(i * 7 + 3);
    endtask

    task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
        int t;
        iIn_valid  = 1'b1;
        iIn_data   = d;
        iIn_last   = last;
        iIn_nbytes = nb;
        t = 0;
        while (1) begin
            @(negedge iClk);
            if (oIn_ready) break;
            t++;
            if (t > 1000) begin
                total++;
                bad++;
                $display("FAIL in_ready_timeout: actual=0 required=1");
                break;
            end
        end
        @(posedge iClk); #1;
        iIn_valid = 1'b0;
        iIn_last  = 1'b0;
    endtask

    task automatic send_msg(input int n, input bit empty_tail, input bit bad_nb,
                            input logic [7:0] junk, input bit exp_err);
        int          nfull, rem, nwords, t;
        logic [31:0] wd;
        logic        lst;
        acc_cnt = 0;
        push_expected(n);
        nfull  = n / 4;
        rem    = n % 4;
        nwords = 0;
        for (int w = 0; w < nfull; w++) begin
            lst = (w == nfull - 1) && (rem == 0) && !empty_tail;
            send_word(mkw(w), lst, (lst && bad_nb) ? 3'd5 : 3'd4);
            nwords++;
        end
        if (rem != 0 || empty_tail || n == 0) begin
            for (int b = 0; b < 4; b++) wd[31-8*b -: 8] = (b < rem) ? msg[4*nfull+b] : junk;
            send_word(wd, 1'b1, 3'(rem));
            nwords++;
        end
        // Offer junk during padding: it must not be accepted.
        iIn_valid  = 1'b1;
        iIn_data   = 32'hDEAD_BEEF;
        iIn_last   = 1'b0;
        iIn_nbytes = 3'd0;
        for (t = 0; t < 3000 && exp_q.size() != 0; t++) begin
            @(posedge iClk); #1;
        end
        iIn_valid = 1'b0;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: actual=%0d required=0 words left", exp_q.size());
            exp_q.delete();
        end
        chk("in_accepted", 64'(acc_cnt), 64'(nwords));
        chk("busy_idle", 64'(oBusy), 64'd0);
        chk("err_flag", 64'(oErr), 64'(exp_err));
    endtask

    task automatic pulse_clear();
        iClear = 1'b1;
        @(posedge iClk); #1;
        iClear = 1'b0;
    endtask

    initial begin : ready_gen
        wait (iReset_n === 1'b1);
        forever begin
            @(posedge iClk); #1;
            iOut_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    initial begin : monitor
        bit   hold;
        exp_t held;
        exp_t e;
        hold = 0;
        forever begin
            @(negedge iClk);
            if (!iReset_n || iClear) begin
                hold = 0;
                if (iClear) exp_q.delete();
            end else begin
                if (iIn_valid && oIn_ready) acc_cnt++;
                if (hold) begin
                    chk("stall_valid", 64'(oOut_valid), 64'd1);
                    chk("stall_stable", 64'({oOut_data, oOut_first, oOut_last, oOut_final}), 64'(held));
                end
                if (oOut_valid && iOut_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_out: actual=%0h required=no output", oOut_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_word", 64'({oOut_data, oOut_first, oOut_last, oOut_final}), 64'(e));
                    end
                end
                hold = oOut_valid && !iOut_ready;
                held = {oOut_data, oOut_first, oOut_last, oOut_final};
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        iReset_n   = 1'b0;
        iClear     = 1'b0;
        iIn_valid  = 1'b0;
        iIn_data   = 32'h0;
        iIn_last   = 1'b0;
        iIn_nbytes = 3'd0;
        iOut_ready = 1'b0;
        repeat (3) @(posedge iClk);
        @(negedge iClk);
        chk("rst_in_ready_lo", 64'(oIn_ready), 64'd0);
        iOut_ready = 1'b1;
        #1;
        chk("rst_in_ready_hi", 64'(oIn_ready), 64'd1);
        chk("rst_valid", 64'(oOut_valid), 64'd0);
        chk("rst_data", 64'(oOut_data), 64'd0);
        chk("rst_flags", 64'({oOut_first, oOut_last, oOut_final}), 64'd0);
        chk("rst_busy", 64'(oBusy), 64'd0);
        chk("rst_err", 64'(oErr), 64'd0);
        @(posedge iClk); #1;
        iReset_n = 1'b1;

        // Pin the model to known padding results.
        fill_pattern();
        push_expected(0);
        chk("pin_empty_n", 64'(exp_q.size()), 64'd16);
        chk("pin_empty_w0", 64'(exp_q[0].data), 64'h8000_0000);
        chk("pin_empty_fin", 64'({exp_q[15].data, exp_q[15].fin}), 64'h1);
        exp_q.delete();
        push_expected(55);
        chk("pin_55_n", 64'(exp_q.size()), 64'd16);
        chk("pin_55_mark", 64'(exp_q[13].data[7:0]), 64'h80);
        chk("pin_55_w14", 64'(exp_q[14].data), 64'h0);
        chk("pin_55_w15", 64'(exp_q[15].data), 64'h1B8);
        exp_q.delete();
        push_expected(56);
        chk("pin_56_n", 64'(exp_q.size()), 64'd32);
        chk("pin_56_w14", 64'(exp_q[14].data), 64'h8000_0000);
        chk("pin_56_w15", 64'({exp_q[15].data, exp_q[15].fin}), 64'h0);
        chk("pin_56_w31", 64'(exp_q[31].data), 64'h1C0);
        exp_q.delete();
        push_expected(64);
        chk("pin_64_w16", 64'(exp_q[16].data), 64'h8000_0000);
        chk("pin_64_w31", 64'(exp_q[31].data), 64'h200);
        exp_q.delete();
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        push_expected(3);
        chk("pin_abc_w0", 64'(exp_q[0].data), 64'h6162_6380);
        chk("pin_abc_w15", 64'({exp_q[15].data, exp_q[15].fin}), 64'h31);
        exp_q.delete();

        // Directed messages, full throughput then with random stalls.
        send_msg(3, 0, 0, 8'h00, 0);
        send_msg(0, 0, 0, 8'hA5, 0);
        fill_pattern();
        send_msg(55, 0, 0, 8'hA5, 0);
        send_msg(56, 0, 0, 8'hA5, 0);
        send_msg(64, 0, 0, 8'hA5, 0);
        stall_en = 1;
        send_msg(8, 1, 0, 8'hA5, 0);
        send_msg(57, 0, 0, 8'h5A, 0);
        send_msg(62, 0, 0, 8'hFF, 0);
        send_msg(60, 0, 0, 8'hA5, 0);

        // nbytes above 4 behaves as 4 and flags an error until cleared.
        send_msg(8, 0, 1, 8'hA5, 1);
        pulse_clear();
        chk("err_cleared_nb", 64'(oErr), 64'd0);

        // Byte counter wraps at 2^CNT_W bytes.
        send_msg(256, 0, 0, 8'hA5, 1);
        pulse_clear();
        chk("err_cleared_ovf", 64'(oErr), 64'd0);

        // Abort mid-block at idx 7 with a word on offer.
        acc_cnt = 0;
        push_expected(64);
        for (int w = 0; w < 7; w++) send_word(mkw(w), 1'b0, 3'd4);
        chk("busy_mid", 64'(oBusy), 64'd1);
        iIn_valid = 1'b1;
        iIn_data  = mkw(7);
        pulse_clear();
        iIn_valid = 1'b0;
        chk("busy_after_clr", 64'(oBusy), 64'd0);
        @(negedge iClk);
        chk("valid_after_clr", 64'(oOut_valid), 64'd0);
        @(posedge iClk); #1;
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        send_msg(3, 0, 0, 8'h00, 0);

        stall_en = 0;
        repeat (4) @(posedge iClk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
